// File: rtl/rv_branch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_branch_unit_pkg
// Description : Shared encodings and helpers for the EX-stage branch unit
//               and its branch history table.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_branch_unit_pkg;

  // Conditional-branch funct3 encodings (RV32I).
  localparam logic [2:0] FUNC3_BEQ  = 3'b000;
  localparam logic [2:0] FUNC3_BNE  = 3'b001;
  localparam logic [2:0] FUNC3_BLT  = 3'b100;
  localparam logic [2:0] FUNC3_BGE  = 3'b101;
  localparam logic [2:0] FUNC3_BLTU = 3'b110;
  localparam logic [2:0] FUNC3_BGEU = 3'b111;

  // Control-transfer class of the EX instruction.
  localparam logic [1:0] BR_JP_NONE   = 2'b00;
  localparam logic [1:0] BR_JP_BRANCH = 2'b01;
  localparam logic [1:0] BR_JP_JAL    = 2'b10;
  localparam logic [1:0] BR_JP_JALR   = 2'b11;

  // 2-bit saturating counter: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
  localparam int unsigned             BHT_CNT_W   = 2;
  localparam logic [BHT_CNT_W-1:0]    BHT_CNT_RST = 2'b01;
  localparam logic [BHT_CNT_W-1:0]    BHT_CNT_MAX = 2'b11;
  localparam logic [BHT_CNT_W-1:0]    BHT_CNT_MIN = 2'b00;

  // Next counter value after one resolved branch, saturating at both ends.
  function automatic logic [BHT_CNT_W-1:0] bht_sat_update(
    input logic [BHT_CNT_W-1:0] cnt,
    input logic                 taken
  );
    logic [BHT_CNT_W-1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != BHT_CNT_MAX) nxt = cnt + 1'b1;
    end else begin
      if (cnt != BHT_CNT_MIN) nxt = cnt - 1'b1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_bht.sv
`default_nettype none
// ============================================================================
// Module      : rv_bht
// Description : Direct-mapped table of 2-bit saturating counters. One
//               combinational read port (prediction = counter MSB) and one
//               synchronous update port. A same-cycle read of the entry being
//               updated returns the old value; there is no bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_bht
  import rv_branch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_pred_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [BHT_CNT_W-1:0] cnt_q [DEPTH];
  logic [BHT_CNT_W-1:0] upd_cnt_d;

  // Saturating next value for the entry addressed by the update port.
  always_comb begin
    upd_cnt_d = bht_sat_update(cnt_q[upd_idx_i], upd_taken_i);
  end

  // Counter storage: reset forces every entry to weak-NT and drops any update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        cnt_q[i] <= BHT_CNT_RST;
      end
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= upd_cnt_d;
    end
  end

  assign rd_pred_o = cnt_q[rd_idx_i][BHT_CNT_W-1];

endmodule
`default_nettype wire

// File: rtl/rv_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv_branch_unit
// Description : EX-stage branch resolution. Evaluates the six conditional
//               compares, resolves jal/jalr, raises flush + redirect only on
//               a misprediction or a jump, and trains the BHT that serves IF
//               predictions.
//               Optional feature macro: BRU_PERF_CNT_EN (branch and
//               misprediction performance counters; ports read 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module rv_branch_unit
  import rv_branch_unit_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned PC_LSB    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_bru_pc_if,
  output logic            o_bru_pred_taken_if,
  input  logic            i_bru_valid_ex,
  input  logic [XLEN-1:0] i_bru_pc_ex,
  input  logic [XLEN-1:0] i_bru_a,
  input  logic [XLEN-1:0] i_bru_b,
  input  logic [2:0]      i_bru_func3_ex,
  input  logic [1:0]      i_bru_is_br_jp_ex,
  input  logic            i_bru_pred_taken_ex,
  input  logic [XLEN-1:0] i_bru_target_ex,
  output logic            o_bru_taken_ex,
  output logic            o_bru_flush_ifid,
  output logic [XLEN-1:0] o_bru_redirect_pc,
  output logic [31:0]     o_bru_br_cnt,
  output logic [31:0]     o_bru_mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_cmp_taken;
  logic             w_is_br;
  logic             w_mispred;
  logic [XLEN-1:0]  w_pc_plus4;

  assign w_if_idx   = i_bru_pc_if[PC_LSB +: IDX_W];
  assign w_ex_idx   = i_bru_pc_ex[PC_LSB +: IDX_W];
  assign w_pc_plus4 = i_bru_pc_ex + XLEN'(4);
  assign w_is_br    = i_bru_valid_ex && (i_bru_is_br_jp_ex == BR_JP_BRANCH);
  assign w_mispred  = w_cmp_taken ^ i_bru_pred_taken_ex;

  // Only the index field of the fetch PC feeds the table.
  logic unused_pc_if;
  assign unused_pc_if = ^i_bru_pc_if;

  // Branch condition from funct3; unlisted encodings behave as BGEU.
  always_comb begin
    w_cmp_taken = 1'b0;
    case (i_bru_func3_ex)
      FUNC3_BEQ:  w_cmp_taken = (i_bru_a == i_bru_b);
      FUNC3_BNE:  w_cmp_taken = (i_bru_a != i_bru_b);
      FUNC3_BLT:  w_cmp_taken = ($signed(i_bru_a) <  $signed(i_bru_b));
      FUNC3_BGE:  w_cmp_taken = ($signed(i_bru_a) >= $signed(i_bru_b));
      FUNC3_BLTU: w_cmp_taken = (i_bru_a <  i_bru_b);
      FUNC3_BGEU: w_cmp_taken = (i_bru_a >= i_bru_b);
      default:    w_cmp_taken = (i_bru_a >= i_bru_b);
    endcase
  end

  // Resolution: a correctly predicted branch needs no redirect, jumps always do.
  always_comb begin
    o_bru_taken_ex    = 1'b0;
    o_bru_flush_ifid  = 1'b0;
    o_bru_redirect_pc = w_pc_plus4;
    if (i_bru_valid_ex) begin
      case (i_bru_is_br_jp_ex)
        BR_JP_BRANCH: begin
          o_bru_taken_ex    = w_cmp_taken;
          o_bru_flush_ifid  = w_mispred;
          o_bru_redirect_pc = w_cmp_taken ? i_bru_target_ex : w_pc_plus4;
        end
        BR_JP_JAL: begin
          o_bru_taken_ex    = 1'b1;
          o_bru_flush_ifid  = 1'b1;
          o_bru_redirect_pc = i_bru_target_ex;
        end
        BR_JP_JALR: begin
          o_bru_taken_ex    = 1'b1;
          o_bru_flush_ifid  = 1'b1;
          o_bru_redirect_pc = {i_bru_target_ex[XLEN-1:1], 1'b0};
        end
        BR_JP_NONE: begin
          o_bru_taken_ex    = 1'b0;
        end
        default: begin
          o_bru_taken_ex    = 1'b0;
        end
      endcase
    end
  end

  rv_bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .rd_idx_i    (w_if_idx),
    .rd_pred_o   (o_bru_pred_taken_if),
    .upd_en_i    (w_is_br),
    .upd_idx_i   (w_ex_idx),
    .upd_taken_i (w_cmp_taken)
  );

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mispred_cnt_q;

  // Count each valid branch cycle once; stalls hold valid low so nothing repeats.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_cnt_q      <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      if (w_is_br) br_cnt_q <= br_cnt_q + 32'd1;
      if (w_is_br && w_mispred) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign o_bru_br_cnt      = br_cnt_q;
  assign o_bru_mispred_cnt = mispred_cnt_q;
`else
  assign o_bru_br_cnt      = 32'd0;
  assign o_bru_mispred_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/rv_branch_unit.md
# rv_branch_unit

Parametrised EX-stage branch resolution unit for the pipelined RV32I core, successor to the single-width branch comparator. It evaluates all six conditional-branch compares at configurable XLEN and resolves jal/jalr. It also owns a direct-mapped table of 2-bit saturating counters (BHT): the IF stage reads a taken/not-taken prediction from it, and EX trains it. The unit flushes IF/ID and supplies the redirect PC only on a misprediction or a jump, not on every taken branch.

## Interface
- XLEN, 32, datapath and PC width
- BHT_DEPTH, 64, number of counters; power of two, at least 2
- PC_LSB, 2, lowest PC bit used for the BHT index
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  reset, synchronous and active-high
- i_bru_pc_if  in  XLEN  PC being fetched
- o_bru_pred_taken_if  out  1  prediction for i_bru_pc_if (counter MSB)
- i_bru_valid_ex  in  1  EX holds a valid instruction; low during stall or bubble
- i_bru_pc_ex  in  XLEN  PC of the EX instruction
- i_bru_a, i_bru_b  in  XLEN  compare operands (rs1, rs2 after forwarding)
- i_bru_func3_ex  in  3  branch funct3
- i_bru_is_br_jp_ex  in  2  encoding: 00 none, 01 branch, 10 jal, 11 jalr
- i_bru_pred_taken_ex  in  1  prediction made in IF, carried down the pipe
- i_bru_target_ex  in  XLEN  computed branch or jump target
- o_bru_taken_ex  out  1  resolved direction (1 for jumps)
- o_bru_flush_ifid  out  1  kill IF/ID and redirect fetch
- o_bru_redirect_pc  out  XLEN  fetch PC to use when flush is high
- o_bru_br_cnt, o_bru_mispred_cnt  out  32 each  performance counters (see Configuration)

## Operation
- Index: idx = pc[PC_LSB +: log2(BHT_DEPTH)]. The IF-side index uses i_bru_pc_if; the EX-side index uses i_bru_pc_ex.
- Compare, by funct3:
  - BEQ, BNE: equality and inequality.
  - BLT, BGE: signed compare.
  - BLTU: unsigned less-than.
  - Any other funct3: treated as BGEU.
- Branch (01), valid:
  - Mispredict = taken XOR i_bru_pred_taken_ex.
  - Flush = mispredict.
  - Redirect = taken ? i_bru_target_ex : i_bru_pc_ex + 4. The +4 add is modulo 2^XLEN.
- jal (10), valid: flush = 1; redirect = target.
- jalr (11), valid: flush = 1; redirect = target with bit 0 cleared.
- none (00), or valid low: flush = 0, taken = 0, redirect = pc_ex + 4.
- BHT training happens only for a valid branch (01) and never for jumps:
  - Taken: counter increments, saturating at 3.
  - Not taken: counter decrements, saturating at 0.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. Prediction = counter[1].

## Timing
- All EX outputs (taken, flush, redirect) are combinational from the EX inputs; zero-cycle latency.
- o_bru_pred_taken_if is a combinational read of the BHT register array.
- The BHT write lands on the rising edge that ends the EX cycle, so it is visible to IF lookups from the next cycle.
- Same-cycle IF read and EX write to the same index: the read returns the old value. No bypass.
- Reset:
  - While i_rst is high, all counters are written to 1 (weak-NT) on each clock edge and no training occurs.
  - o_bru_pred_taken_if = 0 from the first edge with i_rst high.
  - Performance counters clear to 0.
  - Combinational EX outputs follow their inputs even during reset; the pipeline holds valid low in reset.
- Reset asserted mid-training: reset wins; the pending update is dropped.
- Stall: upstream holds valid low, so there is no update and no double counting.

## Configuration
- BRU_PERF_CNT_EN defined:
  - o_bru_br_cnt increments once per cycle with a valid branch (01).
  - o_bru_mispred_cnt increments once per cycle with a valid, mispredicted branch.
  - Both counters are 32 bits and wrap from 0xFFFFFFFF to 0. Jumps are not counted.
- BRU_PERF_CNT_EN undefined: the counter registers are not built; both ports are tied to constant 0. The port list is identical in both builds.

## Structure
- Shared package/config header:
  - FUNC3_* branch encodings and the BR_JP_* 2-bit encodings.
  - The BHT counter reset value (2'b01) and the counter width (2).
- Sub-module rv_bht, a parametrised counter table:
  - Read port: index in, prediction out.
  - Update port: enable, index, taken.
  - Sync reset.
- rv_branch_unit holds the compare, flush and redirect logic and the performance counters.

## Test plan
- Reset, then lookup PC 0x100: o_bru_pred_taken_if = 0. Valid BEQ a=b=5 at pc 0x100, pred 0 -> taken=1, flush=1, redirect = target 0x200.
- Train pc 0x40 with two taken BLT (a=-1, b=1) -> lookup 0x40 predicts 1. A third taken BLT with pred 1 -> flush=0. One not-taken -> still predicts 1 (counter 2). A second not-taken -> predicts 0.
- BLTU a=0xFFFFFFFF, b=1 -> taken=0. BLT with the same operands -> taken=1. BGEU with funct3 3'b111 -> taken=1.
- jalr with target 0x1235 -> flush=1, redirect=0x1234, BHT entry unchanged. jal never modifies the BHT.
- Same-cycle update and lookup of one index from counter 1 with taken -> the lookup reads 0; the next cycle reads 1.
- With BRU_PERF_CNT_EN: 5 valid branches, 2 mispredicted, 1 jal, 1 cycle with valid low -> br_cnt=5, mispred_cnt=2. Reset mid-sequence -> both counters 0. Without the macro, both ports are 0 throughout.
